sysreg_access_arbiter: RTL and testbench

// - Shares the single system-register star bus between NREQ requesters: pipeline read/write stages and the debug unit.
// - Keeps one transaction outstanding at a time; grant order is round-robin.
// - Issues one-cycle rd_en/wr_en pulses to the star bus and routes the read response back to the owner.
// - Bounds every read with a timeout so a silent node cannot hang the core.

---
 rtl/sysreg_access_arbiter_pkg.sv | 25 ++
 rtl/sysreg_access_arbiter_if.sv | 43 ++++
 rtl/sysreg_rr_arbiter.sv | 28 ++
 rtl/sysreg_access_arbiter.sv | 135 +++++++++++++
 tb/tb_sysreg_access_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sysreg_access_arbiter_pkg.sv
// Shared types for the system-register star-bus arbiter: command record,
// address field widths and the access FSM state encoding.
package sysreg_access_arbiter_pkg;

    localparam int unsigned REG_WIDTH     = 64;
    localparam int unsigned SREG_GROUP_W  = 5;
    localparam int unsigned SREG_REGNUM_W = 3;
    localparam int unsigned SREG_PLEVEL_W = 2;

    typedef struct packed {
        logic                     wr;
        logic [SREG_GROUP_W-1:0]  group;
        logic [SREG_REGNUM_W-1:0] regnum;
        logic [SREG_PLEVEL_W-1:0] plevel;
        logic [REG_WIDTH-1:0]     wdata;
    } SysRegCmd;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } SregArbState;

endpackage

// File: rtl/sysreg_access_arbiter_if.sv
// Requester-side handshake and star-bus signals of the sysreg arbiter.
// slave = arbiter view, master = requesters plus the star-bus nodes.
interface sysreg_access_arbiter_if
    import sysreg_access_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = 64
);
    logic [NREQ-1:0]                    req;
    logic [NREQ-1:0]                    req_wr;
    logic [NREQ-1:0][SREG_GROUP_W-1:0]  req_group;
    logic [NREQ-1:0][SREG_REGNUM_W-1:0] req_regnum;
    logic [NREQ-1:0][SREG_PLEVEL_W-1:0] req_plevel;
    logic [NREQ-1:0][DATA_W-1:0]        req_wdata;
    logic [NREQ-1:0]                    gnt;
    logic [NREQ-1:0]                    done;
    logic [DATA_W-1:0]                  rsp_rdata;
    logic                               rsp_err;
    logic                               busy;
    logic                               sreg_rd_en;
    logic                               sreg_wr_en;
    logic [SREG_GROUP_W-1:0]            sreg_group;
    logic [SREG_REGNUM_W-1:0]           sreg_regnum;
    logic [SREG_PLEVEL_W-1:0]           sreg_plevel;
    logic [DATA_W-1:0]                  sreg_wr_val;
    logic                               sreg_rd_valid;
    logic [DATA_W-1:0]                  sreg_rd_val;

    modport slave (
        input  req, req_wr, req_group, req_regnum, req_plevel, req_wdata,
        input  sreg_rd_valid, sreg_rd_val,
        output gnt, done, rsp_rdata, rsp_err, busy,
        output sreg_rd_en, sreg_wr_en, sreg_group, sreg_regnum, sreg_plevel, sreg_wr_val
    );

    modport master (
        output req, req_wr, req_group, req_regnum, req_plevel, req_wdata,
        output sreg_rd_valid, sreg_rd_val,
        input  gnt, done, rsp_rdata, rsp_err, busy,
        input  sreg_rd_en, sreg_wr_en, sreg_group, sreg_regnum, sreg_plevel, sreg_wr_val
    );

endinterface

// File: rtl/sysreg_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant to the first requester
// at or after the pointer, wrapping modulo NREQ.
module sysreg_rr_arbiter #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysreg_access_arbiter.sv
// Shares the system-register star bus between NREQ requesters, one
// transaction at a time, round-robin, with a bounded read wait.
module sysreg_access_arbiter
    import sysreg_access_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned DATA_W  = 64
) (
    input logic                    clk,
    input logic                    rst_n,
    sysreg_access_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    SregArbState       state, state_nx;
    SysRegCmd          cmd, cmd_nx;
    logic [PTR_W-1:0]  owner, owner_nx;
    logic [PTR_W-1:0]  rr_ptr, rr_ptr_nx;
    logic [PTR_W-1:0]  sel_idx;
    logic [NREQ-1:0]   sel_onehot;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nx;
    logic              rsp_err_q, rsp_err_nx;

    sysreg_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (sel_onehot)
    );

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_onehot[i]) sel_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd         <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            cmd         <= cmd_nx;
            owner       <= owner_nx;
            rr_ptr      <= rr_ptr_nx;
            timer       <= timer_nx;
            rsp_rdata_q <= rsp_rdata_nx;
            rsp_err_q   <= rsp_err_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cmd_nx          = cmd;
        owner_nx        = owner;
        rr_ptr_nx       = rr_ptr;
        timer_nx        = timer;
        rsp_rdata_nx    = rsp_rdata_q;
        rsp_err_nx      = rsp_err_q;
        bus.gnt         = '0;
        bus.done        = '0;
        bus.sreg_rd_en  = 1'b0;
        bus.sreg_wr_en  = 1'b0;
        bus.sreg_group  = '0;
        bus.sreg_regnum = '0;
        bus.sreg_plevel = '0;
        bus.sreg_wr_val = '0;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    owner_nx      = sel_idx;
                    cmd_nx.wr     = bus.req_wr[sel_idx];
                    cmd_nx.group  = bus.req_group[sel_idx];
                    cmd_nx.regnum = bus.req_regnum[sel_idx];
                    cmd_nx.plevel = bus.req_plevel[sel_idx];
                    cmd_nx.wdata  = REG_WIDTH'(bus.req_wdata[sel_idx]);
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                bus.gnt[owner]  = 1'b1;
                bus.sreg_wr_en  = cmd.wr;
                bus.sreg_rd_en  = !cmd.wr;
                bus.sreg_group  = cmd.group;
                bus.sreg_regnum = cmd.regnum;
                bus.sreg_plevel = cmd.plevel;
                bus.sreg_wr_val = DATA_W'(cmd.wdata);
                rr_ptr_nx       = (32'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
                if (cmd.wr) begin
                    rsp_rdata_nx = '0;
                    rsp_err_nx   = 1'b0;
                    state_nx     = DONE;
                end else begin
                    timer_nx = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // Response data takes priority over an expiring timer.
                if (bus.sreg_rd_valid) begin
                    rsp_rdata_nx = bus.sreg_rd_val;
                    rsp_err_nx   = 1'b0;
                    state_nx     = DONE;
                end else begin
                    timer_nx = (timer == '1) ? timer : timer + 1'b1;
                    if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rsp_rdata_nx = '0;
                        rsp_err_nx   = 1'b1;
                        state_nx     = DONE;
                    end
                end
            end
            DONE: begin
                bus.done[owner] = 1'b1;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sysreg_access_arbiter.sv
// Directed bench for sysreg_access_arbiter: write alternation, read data,
// timeout, last-cycle data, idle rd_valid and reset in mid-transaction.
module tb_sysreg_access_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DATA_W  = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    sysreg_access_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus_if ();

    sysreg_access_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Cycle 0 is the first IDLE cycle after reset release with both writes pending.
    logic [1:0] exp_gnt  [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                  2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] exp_done [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                                  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

    initial begin
        bus_if.req           = '0;
        bus_if.req_wr        = '0;
        bus_if.req_group     = '0;
        bus_if.req_regnum    = '0;
        bus_if.req_plevel    = '0;
        bus_if.req_wdata     = '0;
        bus_if.sreg_rd_valid = 1'b0;
        bus_if.sreg_rd_val   = '0;

        repeat (2) next_cycle();
        check("rst_gnt",    bus_if.gnt, 0);
        check("rst_done",   bus_if.done, 0);
        check("rst_busy",   bus_if.busy, 0);
        check("rst_rd_en",  bus_if.sreg_rd_en, 0);
        check("rst_wr_en",  bus_if.sreg_wr_en, 0);
        check("rst_rdata",  bus_if.rsp_rdata, 0);
        check("rst_err",    bus_if.rsp_err, 0);
        check("rst_wr_val", bus_if.sreg_wr_val, 0);

        // Both requesters hold writes across reset release.
        bus_if.req_wr        = 2'b11;
        bus_if.req_group[0]  = 5'd3;
        bus_if.req_regnum[0] = 3'd1;
        bus_if.req_plevel[0] = 2'd2;
        bus_if.req_wdata[0]  = 64'h1111_2222_3333_4444;
        bus_if.req_group[1]  = 5'd20;
        bus_if.req_regnum[1] = 3'd5;
        bus_if.req_plevel[1] = 2'd3;
        bus_if.req_wdata[1]  = 64'hAAAA_BBBB_CCCC_DDDD;
        bus_if.req           = 2'b11;
        rst_n                = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            check($sformatf("wr_gnt_c%0d", c),  bus_if.gnt,  exp_gnt[c]);
            check($sformatf("wr_done_c%0d", c), bus_if.done, exp_done[c]);
            if (c == 1) begin
                check("wr0_wr_en",  bus_if.sreg_wr_en, 1);
                check("wr0_rd_en",  bus_if.sreg_rd_en, 0);
                check("wr0_group",  bus_if.sreg_group, 3);
                check("wr0_plevel", bus_if.sreg_plevel, 2);
                check("wr0_wr_val", bus_if.sreg_wr_val, 64'h1111_2222_3333_4444);
            end
            if (c == 4) begin
                check("wr1_group",  bus_if.sreg_group, 20);
                check("wr1_regnum", bus_if.sreg_regnum, 5);
                check("wr1_wr_val", bus_if.sreg_wr_val, 64'hAAAA_BBBB_CCCC_DDDD);
            end
            if (c == 5) begin
                check("wr1_rsp_err",   bus_if.rsp_err, 0);
                check("wr1_rsp_rdata", bus_if.rsp_rdata, 0);
            end
            if (c == 11) bus_if.req = '0;
        end
        next_cycle();
        check("wr_end_busy", bus_if.busy, 0);

        // Pipeline read, node responds after two empty WAIT cycles: done at A+5.
        bus_if.req_wr        = '0;
        bus_if.req_group[0]  = 5'd10;
        bus_if.req_regnum[0] = 3'd7;
        bus_if.req_plevel[0] = 2'd0;
        bus_if.req           = 2'b01;
        next_cycle();
        bus_if.req = '0;
        check("rd_gnt",    bus_if.gnt, 2'b01);
        check("rd_rd_en",  bus_if.sreg_rd_en, 1);
        check("rd_wr_en",  bus_if.sreg_wr_en, 0);
        check("rd_group",  bus_if.sreg_group, 10);
        check("rd_regnum", bus_if.sreg_regnum, 7);
        check("rd_plevel", bus_if.sreg_plevel, 0);
        next_cycle();
        check("rd_wait_busy", bus_if.busy, 1);
        check("rd_wait_done", bus_if.done, 0);
        next_cycle();
        check("rd_wait2_done", bus_if.done, 0);
        next_cycle();
        bus_if.sreg_rd_valid = 1'b1;
        bus_if.sreg_rd_val   = 64'hDEAD_BEEF_0123_4567;
        next_cycle();
        bus_if.sreg_rd_valid = 1'b0;
        check("rd_done",  bus_if.done, 2'b01);
        check("rd_rdata", bus_if.rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        check("rd_err",   bus_if.rsp_err, 0);
        next_cycle();
        check("rd_after_done",  bus_if.done, 0);
        check("rd_after_busy",  bus_if.busy, 0);
        check("rd_after_rdata", bus_if.rsp_rdata, 64'hDEAD_BEEF_0123_4567);

        // Both request reads; pointer now favours requester 1, which times out.
        bus_if.req_group[1] = 5'd7;
        bus_if.req          = 2'b11;
        next_cycle();
        bus_if.req = '0;
        check("to_gnt",   bus_if.gnt, 2'b10);
        check("to_rd_en", bus_if.sreg_rd_en, 1);
        for (int w = 2; w <= 17; w++) next_cycle();
        check("to_last_wait_done", bus_if.done, 0);
        check("to_last_wait_busy", bus_if.busy, 1);
        next_cycle();
        check("to_done",  bus_if.done, 2'b10);
        check("to_err",   bus_if.rsp_err, 1);
        check("to_rdata", bus_if.rsp_rdata, 0);
        next_cycle();
        check("to_idle_busy", bus_if.busy, 0);

        // Pointer back to 0; data arrives in the 16th (final) WAIT cycle.
        bus_if.req = 2'b11;
        next_cycle();
        bus_if.req = '0;
        check("lc_gnt", bus_if.gnt, 2'b01);
        for (int w = 2; w <= 17; w++) next_cycle();
        bus_if.sreg_rd_valid = 1'b1;
        bus_if.sreg_rd_val   = 64'h1234_5678_9ABC_DEF0;
        check("lc_wait_done", bus_if.done, 0);
        next_cycle();
        bus_if.sreg_rd_valid = 1'b0;
        check("lc_done",  bus_if.done, 2'b01);
        check("lc_err",   bus_if.rsp_err, 0);
        check("lc_rdata", bus_if.rsp_rdata, 64'h1234_5678_9ABC_DEF0);
        next_cycle();

        // Stray rd_valid while IDLE must change nothing.
        bus_if.sreg_rd_valid = 1'b1;
        bus_if.sreg_rd_val   = 64'h5555_5555_5555_5555;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            check($sformatf("idle_rv_done_%0d", k),  bus_if.done, 0);
            check($sformatf("idle_rv_busy_%0d", k),  bus_if.busy, 0);
            check($sformatf("idle_rv_rdata_%0d", k), bus_if.rsp_rdata, 64'h1234_5678_9ABC_DEF0);
        end
        bus_if.sreg_rd_valid = 1'b0;
        next_cycle();
        check("idle_rv_err", bus_if.rsp_err, 0);

        // Requester 1 read interrupted by reset in WAIT.
        bus_if.req = 2'b10;
        next_cycle();
        bus_if.req = '0;
        check("rw_gnt", bus_if.gnt, 2'b10);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rw_rst_busy",  bus_if.busy, 0);
        check("rw_rst_gnt",   bus_if.gnt, 0);
        check("rw_rst_done",  bus_if.done, 0);
        check("rw_rst_rd_en", bus_if.sreg_rd_en, 0);
        check("rw_rst_rdata", bus_if.rsp_rdata, 0);
        check("rw_rst_err",   bus_if.rsp_err, 0);
        next_cycle();
        rst_n                = 1'b1;
        bus_if.sreg_rd_valid = 1'b1;
        bus_if.sreg_rd_val   = 64'h9999_9999_9999_9999;
        next_cycle();
        bus_if.sreg_rd_valid = 1'b0;
        check("late_rv_busy",  bus_if.busy, 0);
        check("late_rv_done",  bus_if.done, 0);
        check("late_rv_rdata", bus_if.rsp_rdata, 0);

        // Fresh requester 1 read with an immediate response completes normally.
        bus_if.req = 2'b10;
        next_cycle();
        bus_if.req = '0;
        check("post_gnt", bus_if.gnt, 2'b10);
        next_cycle();
        bus_if.sreg_rd_valid = 1'b1;
        bus_if.sreg_rd_val   = 64'hCAFE_F00D_0000_0042;
        next_cycle();
        bus_if.sreg_rd_valid = 1'b0;
        check("post_done",  bus_if.done, 2'b10);
        check("post_err",   bus_if.rsp_err, 0);
        check("post_rdata", bus_if.rsp_rdata, 64'hCAFE_F00D_0000_0042);
        next_cycle();
        check("post_idle", bus_if.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
